// File: rtl/uart_apb_sequencer.sv
// Autonomous APB master for one uart_top: programs baud/config after reset, then polls
// STATUS and moves bytes between a valid/ready byte stream and TX_DATA/RX_DATA.
module uart_apb_sequencer #(
   parameter int unsigned BAUD_DIV      = 8,
   parameter logic [31:0] UART_CFG_VAL  = 32'h5,
   parameter logic [4:0]  ADDR_UART_CFG = 5'h00,
   parameter logic [4:0]  ADDR_BAUD_CFG = 5'h04,
   parameter logic [4:0]  ADDR_STATUS   = 5'h08,
   parameter logic [4:0]  ADDR_TX_DATA  = 5'h0C,
   parameter logic [4:0]  ADDR_RX_DATA  = 5'h10,
   parameter int unsigned POLL_GAP      = 16,
   parameter int unsigned TIMEOUT       = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  tx_byte_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic [7:0]  rx_byte_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [4:0]  paddr_o,
   output logic [31:0] pwdata_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i,
   output logic        cfg_done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_CFG_BAUD, S_CFG_EN, S_IDLE, S_POLL, S_RD_RX, S_WR_TX, S_GAP
   } state_t;

   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

   state_t      state_r, state_n;
   phase_t      phase_r, phase_n;
   logic [15:0] tcnt_r, tcnt_n, gap_r, gap_n;
   logic        prio_tx_r, prio_tx_n;
   logic [7:0]  tx_hold_r, tx_hold_n;
   logic        psel_r, psel_n, penable_r, penable_n, pwrite_r, pwrite_n;
   logic [4:0]  paddr_r, paddr_n;
   logic [31:0] pwdata_r, pwdata_n;
   logic [7:0]  rx_byte_r, rx_byte_n;
   logic        rx_valid_r, rx_valid_n, tx_ready_r, tx_ready_n;
   logic        cfg_done_r, cfg_done_n, err_r, err_n;
   logic        req_write_s;
   logic [4:0]  req_addr_s;
   logic [31:0] req_wdata_s;
   logic        rx_el_s, tx_el_s;
   logic        unused_s;

   assign unused_s = ^prdata_i[31:8];
   assign rx_el_s  = prdata_i[0] & ~rx_valid_r;
   assign tx_el_s  = tx_valid_i & ~prdata_i[1];

   // Address/data of the transfer owned by the current state
   always_comb begin
      req_write_s = 1'b0;
      req_addr_s  = ADDR_STATUS;
      req_wdata_s = 32'h0;
      case (state_r)
         S_CFG_BAUD: begin req_write_s = 1'b1; req_addr_s = ADDR_BAUD_CFG; req_wdata_s = 32'(BAUD_DIV); end
         S_CFG_EN:   begin req_write_s = 1'b1; req_addr_s = ADDR_UART_CFG; req_wdata_s = UART_CFG_VAL; end
         S_RD_RX:    begin req_write_s = 1'b0; req_addr_s = ADDR_RX_DATA;  req_wdata_s = 32'h0; end
         S_WR_TX:    begin req_write_s = 1'b1; req_addr_s = ADDR_TX_DATA;  req_wdata_s = {24'h0, tx_hold_r}; end
         default:    begin req_write_s = 1'b0; req_addr_s = ADDR_STATUS;   req_wdata_s = 32'h0; end
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state_r;
      phase_n    = phase_r;
      tcnt_n     = tcnt_r;
      gap_n      = gap_r;
      prio_tx_n  = prio_tx_r;
      tx_hold_n  = tx_hold_r;
      psel_n     = psel_r;
      penable_n  = penable_r;
      pwrite_n   = pwrite_r;
      paddr_n    = paddr_r;
      pwdata_n   = pwdata_r;
      rx_byte_n  = rx_byte_r;
      rx_valid_n = rx_valid_r & ~rx_ready_i;
      tx_ready_n = 1'b0;
      cfg_done_n = cfg_done_r;
      err_n      = err_r;
      case (state_r)
         S_IDLE: state_n = (tx_valid_i || !rx_valid_r) ? S_POLL : S_IDLE;
         S_GAP: begin
            if (gap_r == GAP_LAST) begin
               gap_n   = 16'd0;
               state_n = S_IDLE;
            end else begin
               gap_n   = gap_r + 16'd1;
               state_n = S_GAP;
            end
         end
         S_CFG_BAUD, S_CFG_EN, S_POLL, S_RD_RX, S_WR_TX: begin
            case (phase_r)
               PH_IDLE: begin
                  psel_n    = 1'b1;
                  penable_n = 1'b0;
                  pwrite_n  = req_write_s;
                  paddr_n   = req_addr_s;
                  pwdata_n  = req_wdata_s;
                  phase_n   = PH_SETUP;
               end
               PH_SETUP: begin
                  penable_n = 1'b1;
                  tcnt_n    = 16'd0;
                  phase_n   = PH_ACCESS;
               end
               PH_ACCESS: begin
                  if (pready_i) begin
                     psel_n    = 1'b0;
                     penable_n = 1'b0;
                     phase_n   = PH_IDLE;
                     err_n     = err_r | pslverr_i;
                     case (state_r)
                        S_CFG_BAUD: state_n = S_CFG_EN;
                        S_CFG_EN: begin
                           state_n    = S_IDLE;
                           cfg_done_n = cfg_done_r | ~pslverr_i;
                        end
                        S_RD_RX: begin
                           state_n    = S_IDLE;
                           rx_byte_n  = pslverr_i ? rx_byte_r : prdata_i[7:0];
                           rx_valid_n = rx_valid_n | ~pslverr_i;
                        end
                        S_WR_TX: begin
                           state_n    = S_IDLE;
                           tx_ready_n = ~pslverr_i;
                        end
                        S_POLL: begin
                           tx_hold_n = tx_byte_i;
                           if (pslverr_i) begin
                              state_n = S_IDLE;
                           end else if (rx_el_s && tx_el_s) begin
                              state_n   = prio_tx_r ? S_WR_TX : S_RD_RX;
                              prio_tx_n = ~prio_tx_r;
                           end else if (rx_el_s) begin
                              state_n   = S_RD_RX;
                              prio_tx_n = 1'b1;
                           end else if (tx_el_s) begin
                              state_n   = S_WR_TX;
                              prio_tx_n = 1'b0;
                           end else begin
                              state_n = S_GAP;
                              gap_n   = 16'd0;
                           end
                        end
                        default: state_n = S_IDLE;
                     endcase
                  end else if (tcnt_r == TO_LAST) begin
                     // abandoned config writes still advance through the sequence
                     psel_n    = 1'b0;
                     penable_n = 1'b0;
                     phase_n   = PH_IDLE;
                     err_n     = 1'b1;
                     state_n   = (state_r == S_CFG_BAUD) ? S_CFG_EN : S_IDLE;
                  end else begin
                     tcnt_n = tcnt_r + 16'd1;
                  end
               end
               default: begin
                  psel_n    = 1'b0;
                  penable_n = 1'b0;
                  phase_n   = PH_IDLE;
               end
            endcase
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and registered-output update
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= S_CFG_BAUD;
         phase_r    <= PH_IDLE;
         tcnt_r     <= 16'd0;
         gap_r      <= 16'd0;
         prio_tx_r  <= 1'b0;
         tx_hold_r  <= 8'h00;
         psel_r     <= 1'b0;
         penable_r  <= 1'b0;
         pwrite_r   <= 1'b0;
         paddr_r    <= 5'h00;
         pwdata_r   <= 32'h0;
         rx_byte_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         tx_ready_r <= 1'b0;
         cfg_done_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_n;
         phase_r    <= phase_n;
         tcnt_r     <= tcnt_n;
         gap_r      <= gap_n;
         prio_tx_r  <= prio_tx_n;
         tx_hold_r  <= tx_hold_n;
         psel_r     <= psel_n;
         penable_r  <= penable_n;
         pwrite_r   <= pwrite_n;
         paddr_r    <= paddr_n;
         pwdata_r   <= pwdata_n;
         rx_byte_r  <= rx_byte_n;
         rx_valid_r <= rx_valid_n;
         tx_ready_r <= tx_ready_n;
         cfg_done_r <= cfg_done_n;
         err_r      <= err_n;
      end
   end

   assign psel_o     = psel_r;
   assign penable_o  = penable_r;
   assign pwrite_o   = pwrite_r;
   assign paddr_o    = paddr_r;
   assign pwdata_o   = pwdata_r;
   assign rx_byte_o  = rx_byte_r;
   assign rx_valid_o = rx_valid_r;
   assign tx_ready_o = tx_ready_r;
   assign cfg_done_o = cfg_done_r;
   assign err_o      = err_r;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer with a small behavioural APB slave.
module tb_uart_apb_sequencer;

   localparam logic [4:0] A_CFG = 5'h00, A_BAUD = 5'h04, A_ST = 5'h08, A_TX = 5'h0C, A_RX = 5'h10;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [7:0]  tx_byte_i;
   logic        tx_valid_i, tx_ready_o;
   logic [7:0]  rx_byte_o;
   logic        rx_valid_o, rx_ready_i;
   logic        psel_o, penable_o, pwrite_o;
   logic [4:0]  paddr_o;
   logic [31:0] pwdata_o, prdata_i;
   logic        pready_i, pslverr_i, cfg_done_o, err_o;

   logic        pready_en, slverr_rx, stall_tx;
   logic [31:0] status_val, rx_data_val;

   int errors = 0, checks = 0, cyc = 0;
   int n_rxrd = 0, n_txwr = 0, n_txrdy = 0, n_rxbeat = 0;
   logic [7:0]  last_rx = 8'h00;
   logic [4:0]  log_addr[$];
   logic        log_wr[$];
   logic [31:0] log_wd[$];
   int          log_cyc[$];

   uart_apb_sequencer dut (
      .clk_i(clk), .reset_i(reset_i), .tx_byte_i(tx_byte_i), .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o), .rx_byte_o(rx_byte_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
      .pslverr_i(pslverr_i), .cfg_done_o(cfg_done_o), .err_o(err_o));

   always #5 clk = ~clk;

   assign pready_i  = pready_en && !(stall_tx && paddr_o == A_TX);
   assign pslverr_i = slverr_rx && (paddr_o == A_RX);
   assign prdata_i  = (paddr_o == A_ST) ? status_val : (paddr_o == A_RX) ? rx_data_val : 32'hDEAD_0000;

   // Transfer log and handshake counters
   always @(posedge clk) begin
      if (psel_o && penable_o && pready_i) begin
         log_addr.push_back(paddr_o);
         log_wr.push_back(pwrite_o);
         log_wd.push_back(pwdata_o);
         log_cyc.push_back(cyc);
         if (!pwrite_o && paddr_o == A_RX) n_rxrd++;
         if (pwrite_o && paddr_o == A_TX) n_txwr++;
      end
      if (tx_ready_o) n_txrdy++;
      if (rx_valid_o && rx_ready_i) begin
         n_rxbeat++;
         last_rx = rx_byte_o;
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int c = 0;
      while (log_addr.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, 32'(log_addr.size() >= n), 32'd1);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
   endtask

   initial begin
      int c, base, b2, k, mark, n;
      logic [4:0]  seq [4];
      logic [31:0] txd;
      logic [7:0]  held;

      reset_i = 1'b1; tx_byte_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
      pready_en = 1'b1; slverr_rx = 1'b0; stall_tx = 1'b0;
      status_val = 32'h0; rx_data_val = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_psel", psel_o, 1'b0);
      chk("rst_penable", penable_o, 1'b0);
      chk("rst_cfg_done", cfg_done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_rx_valid", rx_valid_o, 1'b0);
      chk("rst_tx_ready", tx_ready_o, 1'b0);
      chk("rst_paddr", paddr_o, 5'h00);
      reset_i = 1'b0;

      // configuration sequence, then idle polling with an empty status
      wait_log(2, 50, "cfg_wait");
      chk("cfg0_addr", log_addr[0], A_BAUD);
      chk("cfg0_wr", log_wr[0], 1'b1);
      chk("cfg0_data", log_wd[0], 32'd8);
      chk("cfg1_addr", log_addr[1], A_CFG);
      chk("cfg1_data", log_wd[1], 32'h5);
      chk("cfg_spacing", log_cyc[1] - log_cyc[0], 32'd3);
      chk("cfg_done", cfg_done_o, 1'b1);
      chk("cfg_err", err_o, 1'b0);
      wait_log(4, 80, "poll_wait");
      chk("poll_addr", log_addr[2], A_ST);
      chk("poll_rd", log_wr[2], 1'b0);
      chk("poll_lat", log_cyc[2] - log_cyc[1], 32'd4);
      chk("poll_gap", log_cyc[3] - log_cyc[2], 32'd20);

      // both paths eligible: round-robin starting with RX
      base = n_txrdy; b2 = n_rxbeat; mark = log_addr.size();
      status_val = 32'hFFFF_FFF1; rx_data_val = 32'hABCD_EF3C;
      tx_valid_i = 1'b1; tx_byte_i = 8'hA5;
      k = n_rxrd + n_txwr; c = 0;
      while ((n_rxrd + n_txwr - k) < 4 && c < 400) begin @(negedge clk); c++; end
      status_val = 32'h0; tx_valid_i = 1'b0;
      chk("rr_wait", 32'(c < 400), 32'd1);
      k = 0; txd = 32'h0;
      for (int i = mark; i < log_addr.size(); i++) begin
         if (log_addr[i] != A_ST && k < 4) begin
            seq[k] = log_addr[i];
            if (log_addr[i] == A_TX) txd = log_wd[i];
            k++;
         end
      end
      chk("rr_0_rx", seq[0], A_RX);
      chk("rr_1_tx", seq[1], A_TX);
      chk("rr_2_rx", seq[2], A_RX);
      chk("rr_3_tx", seq[3], A_TX);
      chk("rr_txdata", txd, 32'h0000_00A5);
      repeat (3) @(negedge clk);
      chk("rr_tx_ready", n_txrdy - base, 32'd2);
      chk("rr_rx_beats", n_rxbeat - b2, 32'd2);
      chk("rr_rx_byte", last_rx, 8'h3C);

      // consumer stalls: byte held, no RX_DATA pops, TX still flows when not full
      rx_ready_i = 1'b0; status_val = 32'h0000_0001; rx_data_val = 32'h1234_5696;
      c = 0;
      while (!rx_valid_o && c < 200) begin @(negedge clk); c++; end
      chk("hold_valid_wait", rx_valid_o, 1'b1);
      chk("hold_byte", rx_byte_o, 8'h96);
      held = rx_byte_o; base = n_rxrd; b2 = n_txwr;
      rx_data_val = 32'h0000_0077; status_val = 32'h0000_0003;
      tx_valid_i = 1'b1; tx_byte_i = 8'h11;
      repeat (150) @(negedge clk);
      chk("hold_still_valid", rx_valid_o, 1'b1);
      chk("hold_stable", rx_byte_o, held);
      chk("hold_no_pop", n_rxrd - base, 32'd0);
      chk("txfull_no_write", n_txwr - b2, 32'd0);
      status_val = 32'h0000_0001;
      repeat (100) @(negedge clk);
      chk("hold_tx_flows", 32'(n_txwr > b2), 32'd1);
      chk("hold_no_pop2", n_rxrd - base, 32'd0);
      tx_valid_i = 1'b0; status_val = 32'h0;
      repeat (8) @(negedge clk);
      rx_ready_i = 1'b1;
      @(negedge clk);
      chk("hold_release", rx_valid_o, 1'b0);
      chk("hold_last", last_rx, 8'h96);

      // slave error on RX_DATA: sticky err, no beat
      b2 = n_rxbeat; base = n_rxrd;
      slverr_rx = 1'b1; status_val = 32'h0000_0001;
      c = 0;
      while (n_rxrd == base && c < 200) begin @(negedge clk); c++; end
      status_val = 32'h0; slverr_rx = 1'b0;
      repeat (3) @(negedge clk);
      chk("slverr_err", err_o, 1'b1);
      chk("slverr_no_beat", n_rxbeat - b2, 32'd0);

      // timeout on both config writes
      pready_en = 1'b0;
      do_reset();
      chk("to_err_cleared", err_o, 1'b0);
      c = 0;
      while (!(psel_o && penable_o) && c < 20) begin @(negedge clk); c++; end
      chk("to_addr", paddr_o, A_BAUD);
      n = 0;
      while (penable_o && n < 200) begin n++; @(negedge clk); end
      chk("to_access_cycles", n, 32'd64);
      chk("to_psel_drop", psel_o, 1'b0);
      chk("to_err", err_o, 1'b1);
      chk("to_cfg_done", cfg_done_o, 1'b0);
      c = 0;
      while (!psel_o && c < 10) begin @(negedge clk); c++; end
      chk("to_next_cfg", paddr_o, A_CFG);
      c = 0;
      while (!(psel_o && paddr_o == A_ST) && c < 200) begin @(negedge clk); c++; end
      chk("to_reaches_poll", 32'(c < 200), 32'd1);
      chk("to_cfg_done2", cfg_done_o, 1'b0);

      // reset during a stalled TX write
      pready_en = 1'b1;
      do_reset();
      wait_log(log_addr.size() + 2, 50, "r6_cfg_wait");
      stall_tx = 1'b1; tx_valid_i = 1'b1; tx_byte_i = 8'h5A;
      c = 0;
      while (!(psel_o && penable_o && paddr_o == A_TX) && c < 200) begin @(negedge clk); c++; end
      chk("r6_tx_access", 32'(c < 200), 32'd1);
      base = n_txrdy;
      #2 reset_i = 1'b1;
      #1;
      chk("r6_psel_async", psel_o, 1'b0);
      chk("r6_penable_async", penable_o, 1'b0);
      repeat (3) @(negedge clk);
      reset_i = 1'b0; stall_tx = 1'b0; tx_valid_i = 1'b0;
      mark = log_addr.size();
      wait_log(mark + 2, 50, "r6_rerun_wait");
      chk("r6_rerun0", log_addr[mark], A_BAUD);
      chk("r6_rerun1", log_addr[mark + 1], A_CFG);
      chk("r6_no_tx_ready", n_txrdy - base, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
